// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read data.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come only from the registered count so they never glitch.
    assign FULL         = (count == DEPTH_CNT);
    assign EMPTY        = (count == '0);
    assign ALMOST_FULL  = (count >= AF_CNT);
    assign ALMOST_EMPTY = (count <= AE_CNT);
    assign COUNT        = count;
    assign OVERFLOW     = overflow;
    assign UNDERFLOW    = underflow;

    assign wr_ok = W_INC && !FULL;
    assign rd_ok = R_INC && !EMPTY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= W_INC && FULL;
            underflow <= R_INC && EMPTY;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; EMPTY after reset hides stale words.
    always_ff @(posedge CLK) begin
        if (wr_ok && !RST) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign RD_DATA = EMPTY ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
        end else if (rd_ok) begin
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    assign RD_DATA = rd_data;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at default parameters.
// Read-data expectations follow the build mode selected by PARAM_SYNC_FIFO_FWFT_EN.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_inc = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       r_inc = 1'b0;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int vectors = 0;
    int miscompares = 0;

    param_sync_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .W_INC       (w_inc),
        .WR_DATA     (wr_data),
        .R_INC       (r_inc),
        .RD_DATA     (rd_data),
        .FULL        (full),
        .EMPTY       (empty),
        .ALMOST_FULL (almost_full),
        .ALMOST_EMPTY(almost_empty),
        .COUNT       (count),
        .OVERFLOW    (overflow),
        .UNDERFLOW   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads one word; in FWFT mode the head is visible before the read edge.
    task automatic read_word(input logic [7:0] expected);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_output("fwft_head", 32'(rd_data), 32'(expected));
        r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
`else
        r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
        check_output("rd_data", 32'(rd_data), 32'(expected));
`endif
    endtask

    task automatic write_word(input logic [7:0] data);
        w_inc   = 1'b1;
        wr_data = data;
        tick();
        w_inc   = 1'b0;
    endtask

    initial begin
        logic [7:0] held;

        #12;
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_empty", 32'(empty), 32'd1);
        check_output("rst_full", 32'(full), 32'd0);
        check_output("rst_ae", 32'(almost_empty), 32'd1);
        check_output("rst_af", 32'(almost_full), 32'd0);
        check_output("rst_rd_data", 32'(rd_data), 32'd0);
        check_output("rst_ovf", 32'(overflow), 32'd0);
        check_output("rst_udf", 32'(underflow), 32'd0);
        #1 rst = 1'b0;
        tick();

        // Fill to full, watching the threshold flags
        for (int i = 0; i < 8; i++) begin
            write_word(8'((i + 1) * 17));
            check_output("fill_count", 32'(count), 32'(i + 1));
            check_output("fill_af", 32'(almost_full), 32'((i + 1) >= 6));
            check_output("fill_ae", 32'(almost_empty), 32'((i + 1) <= 2));
            check_output("fill_full", 32'(full), 32'((i + 1) == 8));
            check_output("fill_empty", 32'(empty), 32'd0);
        end

        write_word(8'hAA);
        check_output("ovf_pulse", 32'(overflow), 32'd1);
        check_output("ovf_count", 32'(count), 32'd8);
        tick();
        check_output("ovf_clear", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++) begin
            read_word(8'((i + 1) * 17));
            check_output("drain_count", 32'(count), 32'(7 - i));
        end
        check_output("drain_empty", 32'(empty), 32'd1);

`ifdef PARAM_SYNC_FIFO_FWFT_EN
        held = 8'h00;
`else
        held = 8'h88;
`endif
        r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
        check_output("udf_pulse", 32'(underflow), 32'd1);
        check_output("udf_rd_data", 32'(rd_data), 32'(held));
        tick();
        check_output("udf_clear", 32'(underflow), 32'd0);

        w_inc = 1'b1;
        r_inc = 1'b1;
        wr_data = 8'h33;
        tick();
        w_inc = 1'b0;
        r_inc = 1'b0;
        check_output("both_empty_count", 32'(count), 32'd1);
        check_output("both_empty_udf", 32'(underflow), 32'd1);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_output("both_empty_rd", 32'(rd_data), 32'h33);
`else
        check_output("both_empty_rd", 32'(rd_data), 32'h88);
`endif
        read_word(8'h33);
        check_output("both_empty_drain", 32'(count), 32'd0);

        // Hold occupancy at 4 with simultaneous traffic so both pointers wrap
        for (int i = 0; i < 4; i++) write_word(8'(8'h40 + i));
        check_output("steady_fill", 32'(count), 32'd4);
        for (int i = 0; i < 20; i++) begin
`ifdef PARAM_SYNC_FIFO_FWFT_EN
            check_output("steady_head", 32'(rd_data), 32'(8'h40 + i));
`endif
            w_inc = 1'b1;
            r_inc = 1'b1;
            wr_data = 8'(8'h44 + i);
            tick();
`ifndef PARAM_SYNC_FIFO_FWFT_EN
            check_output("steady_rd", 32'(rd_data), 32'(8'h40 + i));
`endif
            check_output("steady_count", 32'(count), 32'd4);
        end
        w_inc = 1'b0;
        r_inc = 1'b0;
        for (int i = 0; i < 4; i++) read_word(8'(8'h54 + i));
        check_output("steady_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle with five words stored
        for (int i = 0; i < 5; i++) write_word(8'(8'h60 + i));
        check_output("pre_rst_count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_count", 32'(count), 32'd0);
        check_output("async_rst_empty", 32'(empty), 32'd1);
        check_output("async_rst_ae", 32'(almost_empty), 32'd1);
        check_output("async_rst_rd", 32'(rd_data), 32'd0);
        w_inc = 1'b1;
        wr_data = 8'hEE;
        tick();
        check_output("rst_ignores_wr", 32'(count), 32'd0);
        w_inc = 1'b0;
        #2 rst = 1'b0;
        tick();

        write_word(8'h77);
        check_output("post_rst_count", 32'(count), 32'd1);
        check_output("post_rst_empty", 32'(empty), 32'd0);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        check_output("fwft_fall", 32'(rd_data), 32'h77);
`endif
        read_word(8'h77);
        check_output("post_rst_drain", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of one stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3: depth is DEPTH = 2^ADDR_WIDTH words (default 8).
REQ-003 The block SHALL have parameter AF_LEVEL, default 6: ALMOST_FULL asserts when COUNT >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port W_INC, input, 1 bit: write request.
REQ-008 The block SHALL have port WR_DATA, input, DATA_WIDTH bits: write data.
REQ-009 The block SHALL have port R_INC, input, 1 bit: read request.
REQ-010 The block SHALL have port RD_DATA, output, DATA_WIDTH bits: read data.
REQ-011 The block SHALL have port FULL, output, 1 bit: COUNT == DEPTH.
REQ-012 The block SHALL have port EMPTY, output, 1 bit: COUNT == 0.
REQ-013 The block SHALL have ports ALMOST_FULL and ALMOST_EMPTY, each an output of 1 bit: threshold flags.
REQ-014 The block SHALL have port COUNT, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-015 The block SHALL have ports OVERFLOW and UNDERFLOW, each an output of 1 bit: one-cycle error pulses.

Function
REQ-016 Write and read pointers SHALL each be ADDR_WIDTH+1 bits, with the MSB as wrap bit; the low ADDR_WIDTH bits SHALL address storage, and the pointers SHALL wrap modulo 2*DEPTH with no special case.
REQ-017 A write SHALL be accepted iff W_INC=1 and FULL=0; the accepted write SHALL store WR_DATA at the write address and increment the write pointer on the same edge.
REQ-018 A read SHALL be accepted iff R_INC=1 and EMPTY=0; the accepted read SHALL increment the read pointer.
REQ-019 In default mode, RD_DATA SHALL be registered: on the edge accepting a read it SHALL load the head word, giving 1-cycle latency; it SHALL hold its value otherwise, including on rejected reads.
REQ-020 COUNT SHALL be a register: +1 on write only, -1 on read only, and unchanged when both are accepted or neither is.
REQ-021 With FULL=1, W_INC=1 and R_INC=1: the read SHALL be accepted, the write rejected, OVERFLOW pulsed, and COUNT SHALL become DEPTH-1.
REQ-022 With EMPTY=1, W_INC=1 and R_INC=1: the write SHALL be accepted, the read rejected, UNDERFLOW pulsed, COUNT SHALL become 1, and RD_DATA SHALL be unchanged.
REQ-023 OVERFLOW SHALL be registered and SHALL be 1 for exactly the cycle after any rejected W_INC; UNDERFLOW SHALL do the same for any rejected R_INC.
REQ-024 FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY SHALL be decoded from the registered COUNT only, so that they are glitch-free and valid in the same cycle as COUNT.
REQ-025 The parameters SHALL satisfy AE_LEVEL < AF_LEVEL <= DEPTH; other values are out of range and the block's behaviour for them is undefined.

Reset
REQ-026 RST=1 SHALL immediately, without waiting for a clock edge, clear both pointers, COUNT, RD_DATA, OVERFLOW and UNDERFLOW to 0; EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0.
REQ-027 Storage contents SHALL NOT be reset; stale words SHALL never be readable, because EMPTY=1 after reset.
REQ-028 Reset asserted mid-operation SHALL discard all stored words, and requests SHALL be ignored while RST=1.
REQ-029 The first edge after RST deasserts SHALL accept requests normally.

Configuration
REQ-030 With macro PARAM_SYNC_FIFO_FWFT_EN defined, the block SHALL operate first-word-fall-through: RD_DATA SHALL show the head word combinationally whenever EMPTY=0 (0 when EMPTY=1), and an accepted read SHALL advance to the next word on the edge.
REQ-031 Without PARAM_SYNC_FIFO_FWFT_EN, the registered 1-cycle-latency behaviour of REQ-019 SHALL apply.
REQ-032 All other behaviour SHALL be identical in both builds.

Verification (defaults: DATA_WIDTH=8, DEPTH=8)
REQ-033 Write 0x11..0x88 (8 writes), then 8 reads -> FULL=1 at COUNT=8, ALMOST_FULL from COUNT=6; reads return 0x11..0x88 in order; EMPTY=1 at the end.
REQ-034 From full, W_INC=1 with WR_DATA=0xAA -> OVERFLOW=1 for one cycle, COUNT stays 8, and 0xAA is never read.
REQ-035 From empty, R_INC=1 -> UNDERFLOW=1 for one cycle and RD_DATA unchanged; then W_INC=1 and R_INC=1 together -> COUNT=1, UNDERFLOW=1.
REQ-036 Run 20 writes interleaved with reads at COUNT=4, issuing simultaneous requests each cycle -> COUNT held at 4, the pointers wrap, and the data order is preserved.
REQ-037 Store 5 words, then pulse RST between clock edges -> outputs clear immediately; EMPTY=1 and COUNT=0; the next write/read returns the new word.
REQ-038 With PARAM_SYNC_FIFO_FWFT_EN defined, write 0x5A to an empty FIFO -> RD_DATA=0x5A on the cycle EMPTY falls, before any R_INC.
